// File: rtl/pipe_enq_arbiter.sv
// rtl/pipe_enq_arbiter.sv - round-robin arbiter sharing one enqueue port among NREQ requesters
//
// Purpose:
//   NREQ requesters compete for a single PipeIn-style enqueue port. The winner
//   holds the port for a burst of up to MAXBURST words, then yields. Accepted
//   words land in a one-entry output register, so the downstream ready only
//   gates the owner's ready and never feeds the winner selection.
//
// Ports:
//   CLK            clock, rising edge
//   RST            asynchronous active-high reset
//   req            per-requester request level
//   in_enq_ena     per-requester enqueue strobe
//   in_enq_v       per-requester data, requester i at [i*width +: width]
//   in_enq_rdy     per-requester ready (only the owner's bit can be set)
//   out_enq_ena    enqueue strobe to the shared port
//   out_enq_v      enqueue data to the shared port
//   out_enq_rdy    shared port can accept a word
//   grant_valid    a grant is active
//   grant_id       current or most recent owner

module pipe_enq_arbiter #(
  parameter int width    = 32,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         in_enq_ena,
  input  logic [NREQ*width-1:0]   in_enq_v,
  output logic [NREQ-1:0]         in_enq_rdy,
  output logic                    out_enq_ena,
  output logic [width-1:0]        out_enq_v,
  input  logic                    out_enq_rdy,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAXBURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   owner, owner_n;
  logic [IDW-1:0]   last, last_n;
  logic [CW-1:0]    count, count_n;
  logic             full, full_n;
  logic [width-1:0] data, data_n;

  logic             owner_rdy;
  logic             in_fire;
  logic             out_fire;
  logic [width-1:0] owner_data;
  logic [CW-1:0]    count_inc;
  logic             burst_done;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [IDW-1:0]   cand;
  int               idx;

  // The output register can take a new word when empty or when it is being
  // drained in the same cycle.
  assign owner_rdy = (state == GRANT) && (!full || out_enq_rdy);

  always_comb begin
    in_enq_rdy = '0;
    if (owner_rdy) begin
      in_enq_rdy[owner] = 1'b1;
    end
  end

  // Only the owner's strobe matters; ENA from anyone else is ignored.
  assign in_fire = owner_rdy && in_enq_ena[owner];

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_data = in_enq_v[i*width +: width];
      end
    end
  end

  assign out_enq_ena = full && out_enq_rdy;
  assign out_enq_v   = data;
  assign out_fire    = out_enq_ena;

  assign count_inc  = count + 1'b1;
  assign burst_done = (count_inc == CW'(MAXBURST));

  // Round-robin pick: first set request scanning upward from last+1,
  // wrapping modulo NREQ, so the most recent grantee is considered last.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = IDW'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    count_n = count;
    // A word arriving while one leaves keeps the register full with new data.
    full_n  = in_fire || (full && !out_fire);
    data_n  = in_fire ? owner_data : data;

    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          owner_n = winner;
          last_n  = winner;
          count_n = '0;
        end
      end
      GRANT: begin
        if (in_fire) begin
          count_n = count_inc;
        end
        // A dropped request and the final burst word in the same cycle
        // still give one release: the in_fire term covers it.
        if ((in_fire && burst_done) || (!req[owner] && !in_fire)) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDW'(NREQ - 1);
      count <= '0;
      full  <= 1'b0;
      data  <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      count <= count_n;
      full  <= full_n;
      data  <= data_n;
    end
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = owner;

endmodule

// File: tb/tb_pipe_enq_arbiter.sv
// tb/tb_pipe_enq_arbiter.sv - directed self-checking bench for pipe_enq_arbiter
module tb_pipe_enq_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [3:0]   ena;
  logic [127:0] vin;
  logic [3:0]   in_rdy;
  logic         out_ena;
  logic [31:0]  out_v;
  logic         out_rdy;
  logic         gv;
  logic [1:0]   gid;

  int checks   = 0;
  int failures = 0;

  logic [31:0] nxt [4];
  logic [31:0] outq [$];

  logic        obs_gv;
  logic [1:0]  obs_gid;
  logic [3:0]  obs_rdy;
  logic        obs_oena;
  logic [31:0] obs_ov;

  always #5 clk = ~clk;

  pipe_enq_arbiter #(.width(32), .NREQ(4), .MAXBURST(4)) dut (
    .CLK         (clk),
    .RST         (rst),
    .req         (req),
    .in_enq_ena  (ena),
    .in_enq_v    (vin),
    .in_enq_rdy  (in_rdy),
    .out_enq_ena (out_ena),
    .out_enq_v   (out_v),
    .out_enq_rdy (out_rdy),
    .grant_valid (gv),
    .grant_id    (gid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    rst     = 1'b1;
    req     = '0;
    ena     = '0;
    vin     = '0;
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    outq.delete();
  endtask

  // One cycle: inputs set at edge+1, ENA follows RDY (plus any illegal
  // strobes in bad), outputs sampled at edge+3, then advance to next edge+1.
  task automatic drive(input logic [3:0] r, input logic [3:0] want,
                       input logic ordy, input logic [3:0] bad);
    req     = r;
    out_rdy = ordy;
    for (int i = 0; i < 4; i++) vin[i*32 +: 32] = nxt[i];
    ena = '0;
    #1;
    ena = (in_rdy & want) | bad;
    #1;
    obs_gv   = gv;
    obs_gid  = gid;
    obs_rdy  = in_rdy;
    obs_oena = out_ena;
    obs_ov   = out_v;
    if (out_ena) outq.push_back(out_v);
    for (int i = 0; i < 4; i++) if (ena[i] && in_rdy[i]) nxt[i] = nxt[i] + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] e;
    for (int i = 0; i < 4; i++) nxt[i] = '0;
    reset_dut();

    // Reset state
    #1;
    check("rst_gv", {31'd0, gv}, 32'd0);
    check("rst_gid", {30'd0, gid}, 32'd0);
    check("rst_rdy", {28'd0, in_rdy}, 32'd0);
    check("rst_oena", {31'd0, out_ena}, 32'd0);
    check("rst_ov", out_v, 32'd0);
    #1;

    // Single requester 2, two full bursts separated by one IDLE cycle
    nxt[2] = 32'h10;
    for (int c = 0; c <= 10; c++) begin
      drive(4'b0100, 4'b0100, 1'b1, 4'b0000);
      e = (c == 0 || c == 5 || c == 10) ? 32'd0 : 32'd1;
      check("t1_gv", {31'd0, obs_gv}, e);
      if (c >= 1) check("t1_gid", {30'd0, obs_gid}, 32'd2);
    end
    check("t1_cnt", outq.size(), 32'd8);
    for (int k = 0; k < 8 && k < outq.size(); k++) check("t1_data", outq[k], 32'h10 + k);

    // All four held: grants 0,1,2,3,0, four words each, RDY one-hot or zero
    reset_dut();
    for (int i = 0; i < 4; i++) nxt[i] = 32'h100 * i;
    for (int c = 0; c <= 24; c++) begin
      drive(4'b1111, 4'b1111, 1'b1, 4'b0000);
      check("t2_gv", {31'd0, obs_gv}, (c % 5 != 0) ? 32'd1 : 32'd0);
      if (c % 5 != 0) check("t2_gid", {30'd0, obs_gid}, (c / 5) % 4);
      check("t2_onehot", ($countones(obs_rdy) <= 1) ? 32'd1 : 32'd0, 32'd1);
    end
    drive(4'b0000, 4'b0000, 1'b1, 4'b0000);
    check("t2_cnt", outq.size(), 32'd20);
    for (int k = 0; k < 20 && k < outq.size(); k++) begin
      e = 32'h100 * ((k / 4) % 4) + ((k / 4) == 4 ? 32'd4 : 32'd0) + (k % 4);
      check("t2_data", outq[k], e);
    end

    // Early yield: req[1] drops after 2 words; next grant goes to 3, not 0
    reset_dut();
    nxt[1] = 32'h70;
    drive(4'b0010, 4'b0010, 1'b1, 4'b0000);
    drive(4'b0010, 4'b0010, 1'b1, 4'b0000);
    check("t3_gid", {30'd0, obs_gid}, 32'd1);
    drive(4'b0010, 4'b0010, 1'b1, 4'b0000);
    drive(4'b1001, 4'b0000, 1'b1, 4'b0000);
    check("t3_hold", {31'd0, obs_gv}, 32'd1);
    drive(4'b1001, 4'b0000, 1'b1, 4'b0000);
    check("t3_idle", {31'd0, obs_gv}, 32'd0);
    drive(4'b1001, 4'b0000, 1'b1, 4'b0000);
    check("t3_gv", {31'd0, obs_gv}, 32'd1);
    check("t3_next", {30'd0, obs_gid}, 32'd3);
    drive(4'b0000, 4'b0000, 1'b1, 4'b0000);
    check("t3_cnt", outq.size(), 32'd2);
    if (outq.size() == 2) begin
      check("t3_w0", outq[0], 32'h70);
      check("t3_w1", outq[1], 32'h71);
    end

    // Downstream stall for 5 cycles mid-burst
    reset_dut();
    nxt[0] = 32'h50;
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      drive(4'b0001, 4'b0001, 1'b0, 4'b0000);
      check("t4_ov", obs_ov, 32'h51);
      check("t4_rdy", {28'd0, obs_rdy}, 32'd0);
      check("t4_oena", {31'd0, obs_oena}, 32'd0);
      check("t4_gv", {31'd0, obs_gv}, 32'd1);
    end
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    check("t4_last_gv", {31'd0, obs_gv}, 32'd1);
    drive(4'b0001, 4'b0001, 1'b1, 4'b0000);
    check("t4_rel", {31'd0, obs_gv}, 32'd0);
    check("t4_cnt", outq.size(), 32'd4);
    for (int k = 0; k < 4 && k < outq.size(); k++) check("t4_data", outq[k], 32'h50 + k);

    // Protocol violation: ENA from non-owner 3 carrying 0xDEAD
    reset_dut();
    nxt[0] = 32'h60;
    nxt[3] = 32'hDEAD;
    drive(4'b0000, 4'b0000, 1'b1, 4'b1000);
    drive(4'b0001, 4'b0001, 1'b1, 4'b1000);
    check("t5_idle", {31'd0, obs_gv}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      drive(4'b0001, 4'b0001, 1'b1, 4'b1000);
      check("t5_gid", {30'd0, obs_gid}, 32'd0);
    end
    drive(4'b0000, 4'b0000, 1'b1, 4'b1000);
    check("t5_rel", {31'd0, obs_gv}, 32'd0);
    check("t5_cnt", outq.size(), 32'd4);
    for (int k = 0; k < 4 && k < outq.size(); k++) check("t5_data", outq[k], 32'h60 + k);

    // Asynchronous reset mid-burst
    reset_dut();
    nxt[2] = 32'h80;
    drive(4'b0100, 4'b0100, 1'b1, 4'b0000);
    drive(4'b0100, 4'b0100, 1'b1, 4'b0000);
    drive(4'b0100, 4'b0100, 1'b1, 4'b0000);
    ena = '0;
    #1;
    check("t6_pre_oena", {31'd0, out_ena}, 32'd1);
    check("t6_pre_gid", {30'd0, gid}, 32'd2);
    rst = 1'b1;
    #1;
    check("t6_gv", {31'd0, gv}, 32'd0);
    check("t6_gid", {30'd0, gid}, 32'd0);
    check("t6_rdy", {28'd0, in_rdy}, 32'd0);
    check("t6_oena", {31'd0, out_ena}, 32'd0);
    check("t6_ov", out_v, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(4'b1111, 4'b0000, 1'b1, 4'b0000);
    check("t6_idle", {31'd0, obs_gv}, 32'd0);
    drive(4'b1111, 4'b0000, 1'b1, 4'b0000);
    check("t6_gv2", {31'd0, obs_gv}, 32'd1);
    check("t6_first", {30'd0, obs_gid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
